shared_ram: RTL and testbench

Parametrised single-port word RAM with per-byte write enables, shared between the CPU bus and the video fetch unit. It is the successor to the fixed 16 KiW byte-lane RAM. It adds configurable data width, depth and wait states, a CPU request/acknowledge handshake, and a video read port. A cycle-level arbiter bounds CPU wait to one cycle when both ports contend. The block sits between the 68000 bus glue and the video shifter.

---
 rtl/shared_ram.sv | 108 ++++++++++
 tb/tb_shared_ram.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/shared_ram.sv
// Single-port byte-lane RAM shared by a CPU request/ack port and a video read port.
// Optional SHARED_RAM_FAST_WRITE_EN: CPU writes acknowledge one cycle after grant.
module shared_ram #(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 14,
  parameter int WAIT_CYCLES = 0
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   cpu_req,
  input  logic                   cpu_we,
  input  logic [ADDR_W-1:0]      cpu_addr,
  input  logic [DATA_W-1:0]      cpu_din,
  input  logic [DATA_W/8-1:0]    cpu_be,
  output logic [DATA_W-1:0]      cpu_dout,
  output logic                   cpu_ack,
  input  logic                   vid_req,
  input  logic [ADDR_W-1:0]      vid_addr,
  output logic [DATA_W-1:0]      vid_dout,
  output logic                   vid_valid
);

  localparam int NB    = DATA_W / 8;
  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ACK, ST_HOLD} state_t;

  state_t              state;
  logic [3:0]          wait_cnt;
  logic                cpu_prio;
  logic                cpu_grant;
  logic                vid_go;
  logic                skip_wait;
  logic [ADDR_W-1:0]   mem_addr;
  logic [DATA_W-1:0]   rd_word;

  // The CPU only competes from IDLE; video takes every cycle the CPU is not granted.
  assign cpu_grant = (state == ST_IDLE) && cpu_req && (!vid_req || cpu_prio);
  assign vid_go    = vid_req && !cpu_grant;
  assign mem_addr  = cpu_grant ? cpu_addr : vid_addr;

`ifdef SHARED_RAM_FAST_WRITE_EN
  assign skip_wait = cpu_we;
`else
  assign skip_wait = 1'b0;
`endif

  for (genvar i = 0; i < NB; i++) begin : g_lane
    logic [7:0] lane_mem [DEPTH];

    always_ff @(posedge clk) begin
      if (cpu_grant && cpu_we && cpu_be[i])
        lane_mem[mem_addr] <= cpu_din[8*i +: 8];
    end

    assign rd_word[8*i +: 8] = lane_mem[mem_addr];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      wait_cnt  <= 4'd0;
      cpu_prio  <= 1'b0;
      cpu_ack   <= 1'b0;
      vid_valid <= 1'b0;
      cpu_dout  <= '0;
      vid_dout  <= '0;
    end else begin
      cpu_ack   <= 1'b0;
      vid_valid <= vid_go;
      if (vid_go)
        vid_dout <= rd_word;
      if (cpu_grant && !cpu_we)
        cpu_dout <= rd_word;

      case (state)
        ST_IDLE: begin
          if (cpu_grant) begin
            cpu_prio <= 1'b0;
            if (WAIT_CYCLES == 0 || skip_wait) begin
              state   <= ST_ACK;
              cpu_ack <= 1'b1;
            end else begin
              state    <= ST_WAIT;
              wait_cnt <= WAIT_LOAD;
            end
          end else if (cpu_req && vid_req) begin
            // Video won this contended cycle, so the CPU wins the next one.
            cpu_prio <= 1'b1;
          end
        end
        ST_WAIT: begin
          if (wait_cnt == 4'd0) begin
            state   <= ST_ACK;
            cpu_ack <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        ST_ACK:  state <= cpu_req ? ST_HOLD : ST_IDLE;
        ST_HOLD: if (!cpu_req) state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_shared_ram.sv
// Self-checking bench for shared_ram: random CPU traffic and video reads against an array model.
module tb_shared_ram;

  localparam int DW = 16;
  localparam int AW = 10;
  localparam int NB = DW / 8;
  localparam int WC = 2;
`ifdef SHARED_RAM_FAST_WRITE_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          cpu_req = 1'b0;
  logic          cpu_we = 1'b0;
  logic [AW-1:0] cpu_addr = '0;
  logic [DW-1:0] cpu_din = '0;
  logic [NB-1:0] cpu_be = '0;
  logic [DW-1:0] cpu_dout;
  logic          cpu_ack;
  logic          vid_req = 1'b0;
  logic [AW-1:0] vid_addr = '0;
  logic [DW-1:0] vid_dout;
  logic          vid_valid;

  int n_checks = 0;
  int n_fail = 0;
  logic [DW-1:0] ref_mem [1 << AW];

  shared_ram #(.DATA_W(DW), .ADDR_W(AW), .WAIT_CYCLES(WC)) dut (
    .clk(clk), .reset_n(reset_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_din(cpu_din),
    .cpu_be(cpu_be), .cpu_dout(cpu_dout), .cpu_ack(cpu_ack),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_dout(vid_dout), .vid_valid(vid_valid)
  );

  always #5 clk = ~clk;

  function automatic void model_write(input logic [AW-1:0] a, input logic [DW-1:0] d,
                                      input logic [NB-1:0] be);
    for (int i = 0; i < NB; i++)
      if (be[i]) ref_mem[a][8*i +: 8] = d[8*i +: 8];
  endfunction

  // One full CPU transaction started in IDLE with no video traffic; returns at a negedge in IDLE.
  task automatic cpu_access(input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                            input logic [NB-1:0] be, input string name);
    int k;
    int exp_lat;
    bit seen;
    logic [DW-1:0] exp_data;
    exp_lat  = (we && FAST) ? 1 : 1 + WC;
    exp_data = ref_mem[a];
    cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_din = d; cpu_be = be;
    k = 0; seen = 1'b0;
    while (!seen && k < 20) begin
      @(negedge clk); k++;
      if (cpu_ack) seen = 1'b1;
    end
    n_checks++;
    if (!seen || k != exp_lat) begin
      n_fail++;
      $display("[TB] FAIL %s latency: got %0d cycles (ack seen %0d), expected %0d", name, k, seen, exp_lat);
    end
    if (we) model_write(a, d, be);
    else begin
      n_checks++;
      if (cpu_dout !== exp_data) begin
        n_fail++;
        $display("[TB] FAIL %s data: got %h expected %h", name, cpu_dout, exp_data);
      end
    end
    cpu_req = 1'b0;
    @(negedge clk);
    n_checks++;
    if (cpu_ack !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL %s ack pulse: got %b expected 0", name, cpu_ack);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({cpu_ack, vid_valid, cpu_dout, vid_dout} !== '0) begin
      n_fail++;
      $display("[TB] FAIL reset outputs: got ack=%b valid=%b cdout=%h vdout=%h expected all 0",
               cpu_ack, vid_valid, cpu_dout, vid_dout);
    end
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_byte_lanes();
    cpu_access(1'b1, 10'h010, 16'hABCD, 2'b11, "lane_wr_full");
    cpu_access(1'b1, 10'h010, 16'h1234, 2'b01, "lane_wr_low");
    cpu_access(1'b1, 10'h010, 16'hFFFF, 2'b00, "lane_wr_none");
    cpu_access(1'b0, 10'h010, 16'h0000, 2'b00, "lane_rd");
    n_checks++;
    if (cpu_dout !== 16'hAB34) begin
      n_fail++;
      $display("[TB] FAIL lane_merge: got %h expected AB34", cpu_dout);
    end
  endtask

  task automatic test_latency_hold();
    int k;
    bit extra;
    for (int pass = 0; pass < 2; pass++) begin
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 10'h010;
      k = 0;
      while (!cpu_ack && k < 20) begin @(negedge clk); k++; end
      n_checks++;
      if (k != 1 + WC) begin
        n_fail++;
        $display("[TB] FAIL hold_latency pass %0d: got %0d expected %0d", pass, k, 1 + WC);
      end
      extra = 1'b0;
      repeat (6) begin @(negedge clk); if (cpu_ack) extra = 1'b1; end
      n_checks++;
      if (extra) begin
        n_fail++;
        $display("[TB] FAIL held_req_retrigger: got extra ack 1 expected 0");
      end
      cpu_req = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic test_video_stream();
    logic [DW-1:0] exp;
    for (int n = 0; n < 8; n++)
      cpu_access(1'b1, AW'(n), 16'h1000 + DW'(n), 2'b11, "stream_preload");
    vid_req = 1'b1; vid_addr = '0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      exp = 16'h1000 + DW'(i - 1);
      n_checks++;
      if (vid_valid !== 1'b1 || vid_dout !== exp) begin
        n_fail++;
        $display("[TB] FAIL stream[%0d]: got valid=%b data=%h expected valid=1 data=%h",
                 i - 1, vid_valid, vid_dout, exp);
      end
      if (i < 8) vid_addr = AW'(i);
      else vid_req = 1'b0;
    end
    @(negedge clk);
    n_checks++;
    if (vid_valid !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL stream_end: got valid=%b expected 0", vid_valid);
    end
  endtask

  // Video held high the whole time: video wins the first contended cycle, the CPU the next.
  task automatic test_contention();
    logic [AW-1:0] prev_addr;
    logic exp_valid;
    int k;
    bit seen;
    cpu_access(1'b1, 10'h100, 16'h5A3C, 2'b11, "cont_preload");
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 10'h100; cpu_be = '0;
    vid_req = 1'b1; vid_addr = AW'($urandom_range(7, 0)); prev_addr = vid_addr;
    k = 0; seen = 1'b0;
    while (!seen && k < 20) begin
      @(negedge clk); k++;
      exp_valid = (k != 2);
      n_checks++;
      if (vid_valid !== exp_valid || (exp_valid && vid_dout !== ref_mem[prev_addr])) begin
        n_fail++;
        $display("[TB] FAIL cont_vid cycle %0d: got valid=%b data=%h expected valid=%b data=%h",
                 k, vid_valid, vid_dout, exp_valid, ref_mem[prev_addr]);
      end
      if (cpu_ack) seen = 1'b1;
      vid_addr = AW'($urandom_range(7, 0)); prev_addr = vid_addr;
    end
    n_checks++;
    if (!seen || k != 2 + WC || cpu_dout !== 16'h5A3C) begin
      n_fail++;
      $display("[TB] FAIL cont_cpu: got latency %0d data %h expected %0d data 5a3c", k, cpu_dout, 2 + WC);
    end
    repeat (3) begin
      @(negedge clk);
      n_checks++;
      if (vid_valid !== 1'b1 || vid_dout !== ref_mem[prev_addr] || cpu_ack !== 1'b0) begin
        n_fail++;
        $display("[TB] FAIL cont_hold: got valid=%b data=%h ack=%b expected 1 %h 0",
                 vid_valid, vid_dout, cpu_ack, ref_mem[prev_addr]);
      end
      vid_addr = AW'($urandom_range(7, 0)); prev_addr = vid_addr;
    end
    cpu_req = 1'b0; vid_req = 1'b0;
    @(negedge clk);
    n_checks++;
    if (vid_valid !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL cont_end: got valid=%b expected 0", vid_valid);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 8; n++)
      cpu_access(1'b1, AW'(10'h020 + n), DW'($urandom), 2'b11, "rand_preload");
    for (int i = 0; i < 30; i++)
      cpu_access(1'($urandom_range(1, 0)), AW'(10'h020 + $urandom_range(7, 0)),
                 DW'($urandom), NB'($urandom), "rand");
  endtask

  task automatic test_reset_mid_access();
    bit extra;
    cpu_access(1'b0, 10'h010, 16'h0000, 2'b00, "pre_reset_rd");
    vid_req = 1'b1; vid_addr = '0;
    @(negedge clk);
    vid_req = 1'b0;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 10'h020;
    @(negedge clk);
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    n_checks++;
    if ({cpu_ack, vid_valid, cpu_dout, vid_dout} !== '0) begin
      n_fail++;
      $display("[TB] FAIL mid_reset outputs: got ack=%b valid=%b cdout=%h vdout=%h expected all 0",
               cpu_ack, vid_valid, cpu_dout, vid_dout);
    end
    cpu_req = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    extra = 1'b0;
    repeat (6) begin @(negedge clk); if (cpu_ack) extra = 1'b1; end
    n_checks++;
    if (extra) begin
      n_fail++;
      $display("[TB] FAIL post_reset_ack: got ack 1 expected 0");
    end
    cpu_access(1'b0, 10'h010, 16'h0000, 2'b00, "post_reset_rd");
  endtask

  initial begin
    test_reset();
    test_byte_lanes();
    test_latency_hold();
    test_video_stream();
    test_contention();
    test_random();
    test_reset_mid_access();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
